// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared types and character constants for the LCD time display path.
//   bcd_t    : one BCD digit (4 bits)
//   ascii_t  : one LCD character code (8 bits)
//   time4_t  : a four-digit HH:MM time, hour tens first
// -----------------------------------------------------------------------------
package lcd_pkg;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_DASH  = 8'h2D;
  localparam logic [7:0] ASCII_SPACE = 8'h20;

  typedef logic [3:0] bcd_t;
  typedef logic [7:0] ascii_t;

  typedef struct packed {
    bcd_t msHr;
    bcd_t lsHr;
    bcd_t msMin;
    bcd_t lsMin;
  } time4_t;

endpackage

// File: rtl/lcd_time_display_driver_bcd_to_ascii.sv
// -----------------------------------------------------------------------------
// bcd_to_ascii
// Combinational encoder turning one BCD digit into its LCD character code.
// Digits 0..9 map to OFFSET + digit; any nibble above 9 maps to INVALID so a
// corrupted digit is visible on the display instead of a random glyph.
// Ports:
//   i_digit : BCD digit to encode
//   o_char  : character code for the LCD
// -----------------------------------------------------------------------------
module bcd_to_ascii
  import lcd_pkg::*;
#(
  parameter ascii_t OFFSET  = ASCII_ZERO,
  parameter ascii_t INVALID = ASCII_DASH
) (
  input  bcd_t   i_digit,
  output ascii_t o_char
);

  // Valid digits add onto the offset in 8 bits; the sum can never exceed 8 bits
  // for the offsets used here, so no carry handling is needed.
  always_comb begin
    o_char = INVALID;
    if (i_digit <= 4'd9) begin
      o_char = OFFSET + {4'b0000, i_digit};
    end
  end

endmodule

// File: rtl/lcd_time_display_driver.sv
// -----------------------------------------------------------------------------
// lcd_time_display_driver
// Registered display selector and ASCII encoder for the alarm clock. Picks one
// of three HH:MM sources, encodes each digit as an LCD character and flags
// when the running time equals the alarm time.
// Ports:
//   clk, rst_n                       : clock, asynchronous active-low reset
//   alarm_time_*                     : stored alarm time, BCD
//   current_time_*                   : running clock time, BCD
//   key_*                            : keypad-entry time, BCD
//   show_a                           : display the alarm time (highest priority)
//   show_current_time                : display the keypad-entry time
//   display_ms_hr .. display_ls_min  : registered ASCII characters
//   sound_a                          : registered alarm-match flag
// Build option:
//   LCD_HOUR_BLANK_EN : show a leading hour-tens zero as a space (" 7:07").
// -----------------------------------------------------------------------------
module lcd_time_display_driver
  import lcd_pkg::*;
#(
  parameter ascii_t ASCII_OFFSET = ASCII_ZERO,
  parameter ascii_t INVALID_CHAR = ASCII_DASH
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] alarm_time_ms_hr,
  input  logic [3:0] alarm_time_ls_hr,
  input  logic [3:0] alarm_time_ms_min,
  input  logic [3:0] alarm_time_ls_min,
  input  logic [3:0] current_time_ms_hr,
  input  logic [3:0] current_time_ls_hr,
  input  logic [3:0] current_time_ms_min,
  input  logic [3:0] current_time_ls_min,
  input  logic [3:0] key_ms_hr,
  input  logic [3:0] key_ls_hr,
  input  logic [3:0] key_ms_min,
  input  logic [3:0] key_ls_min,
  input  logic       show_a,
  input  logic       show_current_time,
  output logic [7:0] display_ms_hr,
  output logic [7:0] display_ls_hr,
  output logic [7:0] display_ms_min,
  output logic [7:0] display_ls_min,
  output logic       sound_a
);

`ifdef LCD_HOUR_BLANK_EN
  localparam ascii_t MS_HR_RESET = ASCII_SPACE;
`else
  localparam ascii_t MS_HR_RESET = ASCII_OFFSET;
`endif

  time4_t w_alarm;
  time4_t w_current;
  time4_t w_key;
  time4_t w_sel;
  ascii_t w_encMsHr;
  ascii_t w_encLsHr;
  ascii_t w_encMsMin;
  ascii_t w_encLsMin;
  ascii_t w_charMsHr;
  logic   w_match;

  ascii_t r_displayMsHr;
  ascii_t r_displayLsHr;
  ascii_t r_displayMsMin;
  ascii_t r_displayLsMin;
  logic   r_soundA;

  assign w_alarm   = '{msHr: alarm_time_ms_hr, lsHr: alarm_time_ls_hr,
                       msMin: alarm_time_ms_min, lsMin: alarm_time_ls_min};
  assign w_current = '{msHr: current_time_ms_hr, lsHr: current_time_ls_hr,
                       msMin: current_time_ms_min, lsMin: current_time_ls_min};
  assign w_key     = '{msHr: key_ms_hr, lsHr: key_ls_hr,
                       msMin: key_ms_min, lsMin: key_ls_min};

  // Fixed-priority source choice: the alarm view beats the keypad view, and the
  // running time is what shows when neither is requested.
  always_comb begin
    w_sel = w_current;
    if (show_a) begin
      w_sel = w_alarm;
    end else if (show_current_time) begin
      w_sel = w_key;
    end
  end

  // The alarm compare is a raw 4-bit equality on every digit, so out-of-range
  // nibbles still take part, and it ignores what is being displayed.
  assign w_match = (w_current == w_alarm);

  bcd_to_ascii #(.OFFSET(ASCII_OFFSET), .INVALID(INVALID_CHAR)) u_encMsHr (
    .i_digit (w_sel.msHr),
    .o_char  (w_encMsHr)
  );

  bcd_to_ascii #(.OFFSET(ASCII_OFFSET), .INVALID(INVALID_CHAR)) u_encLsHr (
    .i_digit (w_sel.lsHr),
    .o_char  (w_encLsHr)
  );

  bcd_to_ascii #(.OFFSET(ASCII_OFFSET), .INVALID(INVALID_CHAR)) u_encMsMin (
    .i_digit (w_sel.msMin),
    .o_char  (w_encMsMin)
  );

  bcd_to_ascii #(.OFFSET(ASCII_OFFSET), .INVALID(INVALID_CHAR)) u_encLsMin (
    .i_digit (w_sel.lsMin),
    .o_char  (w_encLsMin)
  );

  // Optional leading-zero blanking on the hour tens digit, applied after the
  // source choice so it affects all three sources alike.
`ifdef LCD_HOUR_BLANK_EN
  assign w_charMsHr = (w_sel.msHr == 4'd0) ? ASCII_SPACE : w_encMsHr;
`else
  assign w_charMsHr = w_encMsHr;
`endif

  // Output registers: everything the LCD sees changes only on a clock edge,
  // giving one cycle of latency from any input to the display and alarm flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_displayMsHr  <= MS_HR_RESET;
      r_displayLsHr  <= ASCII_OFFSET;
      r_displayMsMin <= ASCII_OFFSET;
      r_displayLsMin <= ASCII_OFFSET;
      r_soundA       <= 1'b0;
    end else begin
      r_displayMsHr  <= w_charMsHr;
      r_displayLsHr  <= w_encLsHr;
      r_displayMsMin <= w_encMsMin;
      r_displayLsMin <= w_encLsMin;
      r_soundA       <= w_match;
    end
  end

  assign display_ms_hr  = r_displayMsHr;
  assign display_ls_hr  = r_displayLsHr;
  assign display_ms_min = r_displayMsMin;
  assign display_ls_min = r_displayLsMin;
  assign sound_a        = r_soundA;

endmodule

// File: tb/tb_lcd_time_display_driver.sv
// -----------------------------------------------------------------------------
// tb_lcd_time_display_driver
// Self-checking bench for lcd_time_display_driver: directed cases followed by
// random digits and selects, checked against a behavioural model of the
// expected LCD text. Honours LCD_HOUR_BLANK_EN when it is defined.
// -----------------------------------------------------------------------------
module tb_lcd_time_display_driver;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] alarm   [4];
  logic [3:0] current [4];
  logic [3:0] key     [4];
  logic       showA;
  logic       showKey;
  logic [7:0] dispMsHr;
  logic [7:0] dispLsHr;
  logic [7:0] dispMsMin;
  logic [7:0] dispLsMin;
  logic       soundA;

  int checks = 0;
  int errors = 0;

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  lcd_time_display_driver dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .alarm_time_ms_hr    (alarm[0]),
    .alarm_time_ls_hr    (alarm[1]),
    .alarm_time_ms_min   (alarm[2]),
    .alarm_time_ls_min   (alarm[3]),
    .current_time_ms_hr  (current[0]),
    .current_time_ls_hr  (current[1]),
    .current_time_ms_min (current[2]),
    .current_time_ls_min (current[3]),
    .key_ms_hr           (key[0]),
    .key_ls_hr           (key[1]),
    .key_ms_min          (key[2]),
    .key_ls_min          (key[3]),
    .show_a              (showA),
    .show_current_time   (showKey),
    .display_ms_hr       (dispMsHr),
    .display_ls_hr       (dispLsHr),
    .display_ms_min      (dispMsMin),
    .display_ls_min      (dispLsMin),
    .sound_a             (soundA)
  );

  // Counts one comparison and reports it when the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Model of the LCD character for one digit position: a digit shows as its
  // decimal glyph, anything over nine as a dash, and with blanking enabled a
  // zero in the hour-tens position shows as a space.
  function automatic logic [7:0] modelChar(input logic [3:0] d, input bit hourTens);
`ifdef LCD_HOUR_BLANK_EN
    if (hourTens && d == 4'd0) return 8'h20;
`endif
    if (hourTens) begin end
    if (d > 4'd9) return 8'h2D;
    return 8'h30 + 8'(d);
  endfunction

  // Holds the current inputs through one rising edge, then samples 1 ns later.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
  endtask

  // Compares all outputs with what the model says the display should read for
  // the inputs held across the last edge.
  task automatic checkAll(input string tag);
    logic [3:0] shown [4];
    bit match;
    if (showA)        shown = alarm;
    else if (showKey) shown = key;
    else              shown = current;
    match = 1'b1;
    for (int i = 0; i < 4; i++) if (current[i] != alarm[i]) match = 1'b0;
    checkOutput({tag, "_msHr"},  dispMsHr,  modelChar(shown[0], 1'b1));
    checkOutput({tag, "_lsHr"},  dispLsHr,  modelChar(shown[1], 1'b0));
    checkOutput({tag, "_msMin"}, dispMsMin, modelChar(shown[2], 1'b0));
    checkOutput({tag, "_lsMin"}, dispLsMin, modelChar(shown[3], 1'b0));
    checkOutput({tag, "_sound"}, {7'd0, soundA}, {7'd0, match});
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_msHr"},  dispMsHr,  modelChar(4'd0, 1'b1));
    checkOutput({tag, "_lsHr"},  dispLsHr,  8'h30);
    checkOutput({tag, "_msMin"}, dispMsMin, 8'h30);
    checkOutput({tag, "_lsMin"}, dispLsMin, 8'h30);
    checkOutput({tag, "_sound"}, {7'd0, soundA}, 8'h00);
  endtask

  task automatic setTime(output logic [3:0] t [4], input int a, input int b,
                         input int c, input int d);
    t[0] = 4'(a); t[1] = 4'(b); t[2] = 4'(c); t[3] = 4'(d);
  endtask

  // Directed cases first, then a random sweep, then the summary.
  initial begin
    rst_n   = 1'b0;
    showA   = 1'($urandom);
    showKey = 1'($urandom);
    for (int i = 0; i < 4; i++) begin
      alarm[i]   = 4'($urandom);
      current[i] = 4'($urandom);
      key[i]     = 4'($urandom);
    end
    setTime(alarm, 1, 2, 3, 4);
    setTime(current, 1, 2, 3, 4);
    repeat (3) @(posedge clk);
    #1;
    checkReset("resetHeld");
    #3;
    rst_n = 1'b1;

    setTime(key, 1, 2, 3, 4);
    setTime(alarm, 0, 9, 5, 9);
    setTime(current, 2, 3, 5, 9);
    showA = 1'b0; showKey = 1'b1;
    applyStimulus();
    checkAll("key1234");
    checkOutput("key1234_lit", dispLsMin, 8'h34);

    // Mid-run asynchronous reset must clear without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    checkReset("asyncReset");
    #1;
    rst_n = 1'b1;

    showA = 1'b1; showKey = 1'b0;
    applyStimulus();
    checkAll("alarm0959");
    checkOutput("alarm0959_lit", dispLsHr, 8'h39);
    showKey = 1'b1;
    applyStimulus();
    checkAll("alarmPriority");

    showA = 1'b0; showKey = 1'b0;
    applyStimulus();
    checkAll("current2359");
    checkOutput("noMatch_lit", {7'd0, soundA}, 8'h00);

    setTime(current, 0, 7, 0, 7); setTime(alarm, 0, 7, 0, 7);
    applyStimulus();
    checkAll("match0707");
    checkOutput("match0707_lit", {7'd0, soundA}, 8'h01);
    setTime(current, 0, 0, 0, 0); setTime(alarm, 0, 0, 0, 0);
    applyStimulus();
    checkAll("match0000");
    setTime(current, 2, 3, 5, 9); setTime(alarm, 2, 3, 5, 9);
    applyStimulus();
    checkAll("match2359");
    current[3] = 4'd8;
    applyStimulus();
    checkAll("matchDrop");
    checkOutput("matchDrop_lit", {7'd0, soundA}, 8'h00);

    key[3] = 4'hC; showKey = 1'b1;
    applyStimulus();
    checkAll("invalidKey");
    checkOutput("invalidKey_lit", dispLsMin, 8'h2D);

    setTime(current, 0, 5, 4, 2); showKey = 1'b0;
    applyStimulus();
    checkAll("hourZero");

    // Random sweep: mostly valid digits, occasional invalid ones, and a forced
    // alarm match about a quarter of the time.
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        alarm[i]   = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        current[i] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        key[i]     = 4'($urandom);
      end
      if ($urandom_range(0, 3) == 0) current = alarm;
      showA   = 1'($urandom);
      showKey = 1'($urandom);
      applyStimulus();
      checkAll("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_time_display_driver.md
Name: lcd_time_display_driver

Overview:
- Registered display selector and ASCII encoder for the digital alarm clock.
- Chooses one of three 4-digit BCD time sources (alarm time, keypad-entry time, current time) and encodes each digit as an 8-bit ASCII character for the LCD.
- Raises sound_a when the current time equals the alarm time.
- Sits between the alarm/keypad/counter blocks and the LCD character interface.

Parameters:
- ASCII_OFFSET, 8'h30, value added to a valid BCD digit to form its character code ('0').
- INVALID_CHAR, 8'h2D, character emitted for any digit nibble > 9 ('-').

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- alarm_time_ms_hr / alarm_time_ls_hr / alarm_time_ms_min / alarm_time_ls_min  in  4 each  stored alarm time, BCD digits.
- current_time_ms_hr / current_time_ls_hr / current_time_ms_min / current_time_ls_min  in  4 each  running clock time, BCD digits.
- key_ms_hr / key_ls_hr / key_ms_min / key_ls_min  in  4 each  keypad-entry time, BCD digits.
- show_a  in  1  select alarm time for display.
- show_current_time  in  1  select keypad-entry time for display. The signal name is historical; behaviour is as stated here.
- display_ms_hr / display_ls_hr / display_ms_min / display_ls_min  out  8 each  ASCII characters, hour tens to minute units.
- sound_a  out  1  alarm match indication.

Behaviour:
- Reset is asynchronous on rst_n low and is released synchronously at the first clk edge with rst_n high.
  - All four display outputs = ASCII_OFFSET (shows "00:00").
  - sound_a = 0.
- Source selection is evaluated each cycle, fixed priority:
  - show_a = 1: alarm digits.
  - else show_current_time = 1: key digits.
  - else: current-time digits.
  - show_a wins when both selects are 1.
- Encoding, per digit independently:
  - d ≤ 9: output = ASCII_OFFSET + d, using 8-bit arithmetic with no carry-out concern.
  - d ≥ 10: output = INVALID_CHAR.
- Latency: the display outputs and sound_a are registered. A change on any input is visible exactly 1 clk edge later. Outputs are stable between edges.
- sound_a = 1 in the cycle after all four current_time digits equal the corresponding alarm_time digits, including 00:00 == 00:00.
  - sound_a is independent of show_a and show_current_time.
  - sound_a drops 1 cycle after any digit mismatch.
  - The comparison is raw 4-bit; invalid digits still compare.
- Select changes and data changes on the same edge: the new select is applied to the new data in that same registration.
- No handshakes and no internal FSM; the block is a pure registered datapath.

Optional Feature:
- Macro: LCD_HOUR_BLANK_EN.
- Defined: if the selected ms_hr digit is 0, display_ms_hr = 8'h20 (space), so 07:07 shows " 7:07". This applies to all three sources. The reset value of display_ms_hr becomes 8'h20.
- Not defined: ms_hr is encoded like every other digit (0 → 8'h30).
- sound_a is unaffected either way.

Decomposition:
- Shared package lcd_pkg:
  - ASCII_ZERO = 8'h30
  - ASCII_DASH = 8'h2D
  - ASCII_SPACE = 8'h20
  - typedef bcd_t (4-bit)
  - typedef ascii_t (8-bit)
  - typedef time4_t (struct of four bcd_t: ms_hr, ls_hr, ms_min, ls_min)
- One sub-module, bcd_to_ascii: combinational, 4-bit digit in, 8-bit character out, with an invalid-digit substitute. Instantiate it four times.
- Selection, comparison and output registers live in the top module.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs → all displays 8'h30, sound_a=0. Assert rst_n low mid-run → outputs clear immediately, without waiting for a clock edge.
- key = 1,2,3,4; show_current_time=1, show_a=0 → after 1 edge, displays 8'h31, 8'h32, 8'h33, 8'h34.
- alarm = 0,9,5,9; show_a=1, show_current_time=0 → 8'h30, 8'h39, 8'h35, 8'h39. Then set show_current_time=1 as well → alarm is still shown.
- current = 2,3,5,9; both selects 0 → 8'h32, 8'h33, 8'h35, 8'h39. Alarm = 0,9,5,9 → sound_a=0.
- Match cases:
  - current = alarm = 07:07 → sound_a=1 after 1 edge.
  - 00:00 = 00:00 → sound_a=1.
  - 23:59 = 23:59 → sound_a=1.
  - Then change current_time_ls_min to 8 → sound_a=0 after 1 edge.
- Invalid digit: key_ls_min=4'hC with show_current_time=1 → display_ls_min=8'h2D. With LCD_HOUR_BLANK_EN defined and current ms_hr=0 → display_ms_hr=8'h20.
